// File: rtl/gnss_code_mem.sv
// Multi-bank 1-bit spreading-code store: CPU loads WORD chips per write, NCH channels
// prefetch through one time-shared read port. Optional epoch flags: GNSS_CODE_EPOCH_EN.
module gnss_code_mem #(
  parameter int NCH      = 12,
  parameter int CODELEN  = 4092,
  parameter int CODEBITS = 12,
  parameter int NBANK    = 2,
  parameter int BANKBITS = 1,
  parameter int WORD     = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    ld_start,
  input  logic [BANKBITS-1:0]     ld_bank,
  input  logic                    wr,
  input  logic [WORD-1:0]         wdata,
  output logic                    ld_busy,
  output logic                    ld_done,
  input  logic [NCH*CODEBITS-1:0] nchip_n,
  input  logic [NCH*BANKBITS-1:0] bank_sel,
  input  logic [NCH-1:0]          full_chip,
  output logic [NCH-1:0]          code_o,
  output logic [NCH-1:0]          epoch_o
);

  localparam int DEPTH = NBANK * CODELEN;
  localparam int AW    = $clog2(DEPTH);
  localparam int SW    = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int CW    = $clog2(CODELEN + WORD + 1);
  localparam logic [AW-1:0]       CODELEN_A = AW'(CODELEN);
  localparam logic [CODEBITS-1:0] LAST_CHIP = CODEBITS'(CODELEN - 1);

  typedef enum logic {IDLE, LOAD} state_t;

  state_t        state_reg, state_next;
  logic [AW-1:0] ptr_reg, ptr_next;
  logic [CW-1:0] cnt_reg, cnt_next;
  logic          ld_done_reg, ld_done_next;
  logic          we;

  logic mem [DEPTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= IDLE;
      ptr_reg     <= '0;
      cnt_reg     <= '0;
      ld_done_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      ptr_reg     <= ptr_next;
      cnt_reg     <= cnt_next;
      ld_done_reg <= ld_done_next;
    end
  end

  // ld_start restarts a load from any state and masks a coincident wr
  always_comb begin
    state_next   = state_reg;
    ptr_next     = ptr_reg;
    cnt_next     = cnt_reg;
    ld_done_next = ld_done_reg;
    we           = 1'b0;
    if (ld_start) begin
      state_next   = LOAD;
      ptr_next     = AW'(ld_bank) * CODELEN_A;
      cnt_next     = '0;
      ld_done_next = 1'b0;
    end else if (state_reg == LOAD && wr) begin
      we       = 1'b1;
      ptr_next = ptr_reg + AW'(WORD);
      cnt_next = cnt_reg + CW'(WORD);
      if (cnt_next >= CW'(CODELEN)) begin
        state_next   = IDLE;
        ld_done_next = 1'b1;
      end
    end
  end

  assign ld_busy = (state_reg == LOAD);
  assign ld_done = ld_done_reg;

  // Per-channel views of the packed request buses
  logic [CODEBITS-1:0] nchip_arr [NCH];
  logic [BANKBITS-1:0] bank_arr  [NCH];
  genvar gi;
  generate
    for (gi = 0; gi < NCH; gi++) begin : g_unpack
      assign nchip_arr[gi] = nchip_n[gi*CODEBITS +: CODEBITS];
      assign bank_arr[gi]  = bank_sel[gi*BANKBITS +: BANKBITS];
    end
  endgenerate

  logic [SW-1:0]       slot_reg;
  logic [CODEBITS-1:0] cur_chip, next_chip;
  logic [AW-1:0]       rd_addr_next, rd_addr_reg;
  logic [SW-1:0]       tag1_reg, tag2_reg;
  logic                rd_data_reg;
  logic [NCH-1:0]      pref_reg;
  logic [NCH-1:0]      code_reg;

  always_comb begin
    cur_chip     = nchip_arr[slot_reg];
    next_chip    = (cur_chip == LAST_CHIP) ? '0 : cur_chip + 1'b1;
    rd_addr_next = AW'(bank_arr[slot_reg]) * CODELEN_A + AW'(next_chip);
  end

  // Chips past CODELEN in the final word are dropped so the next bank is untouched
  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < WORD; i++) begin
        if (cnt_reg + CW'(i) < CW'(CODELEN))
          mem[ptr_reg + AW'(i)] <= wdata[i];
      end
    end
    rd_data_reg <= mem[rd_addr_reg];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      slot_reg    <= '0;
      rd_addr_reg <= '0;
      tag1_reg    <= '0;
      tag2_reg    <= '0;
      pref_reg    <= '0;
      code_reg    <= '0;
    end else begin
      slot_reg    <= (slot_reg == SW'(NCH - 1)) ? '0 : slot_reg + 1'b1;
      rd_addr_reg <= rd_addr_next;
      tag1_reg    <= slot_reg;
      tag2_reg    <= tag1_reg;
      for (int c = 0; c < NCH; c++) begin
        if (tag2_reg == SW'(c))
          pref_reg[c] <= rd_data_reg;
        if (full_chip[c])
          code_reg[c] <= pref_reg[c];
      end
    end
  end

  assign code_o = code_reg;

`ifdef GNSS_CODE_EPOCH_EN
  logic           ep1_reg, ep2_reg;
  logic [NCH-1:0] pref_ep_reg;
  logic [NCH-1:0] epoch_reg;

  // Epoch flag rides alongside the chip so it lands in the same channel slot
  always_ff @(posedge clk) begin
    if (rst) begin
      ep1_reg     <= 1'b0;
      ep2_reg     <= 1'b0;
      pref_ep_reg <= '0;
      epoch_reg   <= '0;
    end else begin
      ep1_reg <= (next_chip == '0);
      ep2_reg <= ep1_reg;
      for (int c = 0; c < NCH; c++) begin
        if (tag2_reg == SW'(c))
          pref_ep_reg[c] <= ep2_reg;
        epoch_reg[c] <= full_chip[c] ? pref_ep_reg[c] : 1'b0;
      end
    end
  end

  assign epoch_o = epoch_reg;
`else
  assign epoch_o = '0;
`endif

endmodule

// File: tb/tb_gnss_code_mem.sv
// Directed bench for gnss_code_mem: load, readback, wrap, simultaneous strobes,
// reset mid-load and ignored writes. Bank 0 holds 0x1234 words, bank 1 holds 0xA5C3.
module tb_gnss_code_mem;

  localparam int NCH      = 12;
  localparam int CODELEN  = 4092;
  localparam int CODEBITS = 12;
  localparam int NBANK    = 2;
  localparam int BANKBITS = 1;
  localparam int WORD     = 16;

  logic                    clk = 1'b0;
  logic                    rst = 1'b1;
  logic                    ld_start = 1'b0;
  logic [BANKBITS-1:0]     ld_bank = '0;
  logic                    wr = 1'b0;
  logic [WORD-1:0]         wdata = '0;
  logic                    ld_busy;
  logic                    ld_done;
  logic [NCH*CODEBITS-1:0] nchip_n = '0;
  logic [NCH*BANKBITS-1:0] bank_sel = '0;
  logic [NCH-1:0]          full_chip = '0;
  logic [NCH-1:0]          code_o;
  logic [NCH-1:0]          epoch_o;

  int checks = 0;
  int errors = 0;

  gnss_code_mem #(
    .NCH(NCH), .CODELEN(CODELEN), .CODEBITS(CODEBITS),
    .NBANK(NBANK), .BANKBITS(BANKBITS), .WORD(WORD)
  ) dut (
    .clk(clk), .rst(rst), .ld_start(ld_start), .ld_bank(ld_bank),
    .wr(wr), .wdata(wdata), .ld_busy(ld_busy), .ld_done(ld_done),
    .nchip_n(nchip_n), .bank_sel(bank_sel), .full_chip(full_chip),
    .code_o(code_o), .epoch_o(epoch_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: chip idx of a bank is bit (idx mod 16) of that bank's load word
  function automatic logic exp_chip(input int bank, input int idx);
    logic [15:0] p;
    p = (bank == 0) ? 16'h1234 : 16'hA5C3;
    return p[idx % 16];
  endfunction

  function automatic int next_idx(input int x);
    return (x == CODELEN - 1) ? 0 : x + 1;
  endfunction

  task automatic load_bank(input int bank, input logic [15:0] pat, input int nwr);
    @(negedge clk);
    ld_start = 1'b1;
    ld_bank  = BANKBITS'(bank);
    @(negedge clk);
    ld_start = 1'b0;
    check("ld_start_busy", 32'(ld_busy), 32'd1);
    check("ld_start_done", 32'(ld_done), 32'd0);
    for (int i = 0; i < nwr; i++) begin
      wr    = 1'b1;
      wdata = pat;
      @(negedge clk);
      if (i < 255) begin
        check("ld_busy_wr", 32'(ld_busy), 32'd1);
      end else begin
        check("ld_busy_end", 32'(ld_busy), 32'd0);
        check("ld_done_end", 32'(ld_done), 32'd1);
      end
    end
    wr = 1'b0;
    $display("load bank %0d pattern %h words %0d busy=%0d done=%0d", bank, pat, nwr, ld_busy, ld_done);
  endtask

  task automatic read_one(input int ch, input int bank, input int idx, input logic exp);
    @(negedge clk);
    nchip_n[ch*CODEBITS +: CODEBITS]  = CODEBITS'(idx);
    bank_sel[ch*BANKBITS +: BANKBITS] = BANKBITS'(bank);
    repeat (NCH + 3) @(negedge clk);
    full_chip[ch] = 1'b1;
    @(negedge clk);
    full_chip[ch] = 1'b0;
    check($sformatf("read_ch%0d_b%0d_n%0d", ch, bank, idx), 32'(code_o[ch]), 32'(exp));
    $display("read ch %0d bank %0d nchip %0d code=%0d exp=%0d", ch, bank, idx, code_o[ch], exp);
  endtask

  initial begin
    int nlist [NCH] = '{0, 5, 17, 31, 101, 200, 1000, 2047, 3000, 4000, 4090, 4091};
    logic [NCH-1:0] exp_vec;

    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_code", 32'(code_o), 32'd0);
    check("rst_epoch", 32'(epoch_o), 32'd0);
    check("rst_busy", 32'(ld_busy), 32'd0);
    check("rst_done", 32'(ld_done), 32'd0);
    $display("reset code=%h epoch=%h busy=%0d done=%0d", code_o, epoch_o, ld_busy, ld_done);

    load_bank(0, 16'h1234, 256);
    load_bank(1, 16'hA5C3, 256);

    // chip 17 of 0xA5C3 words = bit1 = 1
    read_one(3, 1, 16, 1'b1);
    // bank 0 must still hold 0x1234: chip 2 = 1, chip 17 = 0
    read_one(1, 0, 1, 1'b1);
    read_one(0, 0, 16, 1'b0);

    // wrap: next(4091) = 0, chip 0 of 0xA5C3 = 1
    read_one(5, 1, 4091, 1'b1);
`ifdef GNSS_CODE_EPOCH_EN
    check("wrap_epoch_pulse", 32'(epoch_o), 32'h20);
    @(negedge clk);
    check("wrap_epoch_clear", 32'(epoch_o), 32'd0);
`else
    check("wrap_epoch_off", 32'(epoch_o), 32'd0);
`endif

    // reset in the middle of a load of bank 0
    load_bank(0, 16'hFFFF, 100);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_busy", 32'(ld_busy), 32'd0);
    check("midrst_done", 32'(ld_done), 32'd0);
    check("midrst_code", 32'(code_o), 32'd0);
    $display("reset mid-load busy=%0d done=%0d code=%h", ld_busy, ld_done, code_o);

    // writes with no load in progress are ignored
    for (int i = 0; i < 5; i++) begin
      wr = 1'b1;
      wdata = 16'h0000;
      @(negedge clk);
    end
    wr = 1'b0;
    check("idle_wr_busy", 32'(ld_busy), 32'd0);
    check("idle_wr_done", 32'(ld_done), 32'd0);
    $display("idle writes busy=%0d done=%0d", ld_busy, ld_done);

    load_bank(0, 16'h1234, 256);

    // overrun: writes after completion must not touch memory or flags
    for (int i = 0; i < 10; i++) begin
      wr = 1'b1;
      wdata = 16'h0000;
      @(negedge clk);
    end
    wr = 1'b0;
    check("overrun_busy", 32'(ld_busy), 32'd0);
    check("overrun_done", 32'(ld_done), 32'd1);
    $display("overrun writes busy=%0d done=%0d", ld_busy, ld_done);

    // all channels strobe together; even channels read bank 1, odd read bank 0
    exp_vec = '0;
    for (int c = 0; c < NCH; c++) begin
      nchip_n[c*CODEBITS +: CODEBITS]  = CODEBITS'(nlist[c]);
      bank_sel[c*BANKBITS +: BANKBITS] = BANKBITS'((c % 2 == 0) ? 1 : 0);
      exp_vec[c] = exp_chip((c % 2 == 0) ? 1 : 0, next_idx(nlist[c]));
    end
    repeat (NCH + 3) @(negedge clk);
    full_chip = '1;
    @(negedge clk);
    full_chip = '0;
    for (int c = 0; c < NCH; c++) begin
      check($sformatf("simul_ch%0d", c), 32'(code_o[c]), 32'(exp_vec[c]));
      $display("simultaneous ch %0d nchip %0d code=%0d exp=%0d", c, nlist[c], code_o[c], exp_vec[c]);
    end
`ifdef GNSS_CODE_EPOCH_EN
    check("simul_epoch", 32'(epoch_o), 32'h800);
`else
    check("simul_epoch_off", 32'(epoch_o), 32'd0);
`endif
    @(negedge clk);
    check("hold_code", 32'(code_o), 32'(exp_vec));
    $display("hold code=%h exp=%h", code_o, exp_vec);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
